// File: rtl/mac_unit_vert_seq.sv
// Bit-column ("vertical") MAC: one signed activation vector per job and one
// weight bit-column descriptor per accepted cycle. The result is handed off on a valid/ready port.
module mac_unit_vert_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int VEC_LENGTH  = 16,
    parameter int WEIGHT_BITS = 8,
    parameter int NSEL        = VEC_LENGTH / 2,
    parameter int SEL_WIDTH   = $clog2(VEC_LENGTH) + 1,
    parameter int SUM_WIDTH   = DATA_WIDTH + $clog2(VEC_LENGTH),
    parameter int ACC_WIDTH   = DATA_WIDTH + WEIGHT_BITS + $clog2(VEC_LENGTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_act_valid,
    output logic                             o_act_ready,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0] i_act,
    input  logic                             i_act_signed_w,
    input  logic                             i_col_valid,
    output logic                             o_col_ready,
    input  logic [NSEL*SEL_WIDTH-1:0]        i_col_sel,
    input  logic                             i_col_skip_zero,
    input  logic                             i_col_ham_en,
    input  logic                             i_col_ham_sign,
    input  logic [SEL_WIDTH-1:0]             i_col_ham_sel,
    output logic                             o_res_valid,
    input  logic                             i_res_ready,
    output logic signed [ACC_WIDTH-1:0]      o_result
);
    localparam int IDX_WIDTH     = $clog2(WEIGHT_BITS);
    localparam int ACT_IDX_WIDTH = $clog2(VEC_LENGTH);
    localparam int H_WIDTH       = SUM_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_COL = IDX_WIDTH'(WEIGHT_BITS - 1);

    typedef enum logic [1:0] {IDLE, COL, DONE} state_t;

    state_t                       r_state;
    logic signed [DATA_WIDTH-1:0] r_act [VEC_LENGTH];
    logic                         r_signed_w;
    logic signed [SUM_WIDTH-1:0]  r_sum_act;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  r_result;
    logic [IDX_WIDTH-1:0]         r_col_idx;
    logic                         r_act_ready;
    logic                         r_col_ready;
    logic                         r_res_valid;

    logic signed [SUM_WIDTH-1:0]  w_in_sum;
    logic signed [SUM_WIDTH-1:0]  w_sel_sum;
    logic signed [DATA_WIDTH-1:0] w_ham_act;
    logic signed [H_WIDTH-1:0]    w_p;
    logic signed [H_WIDTH-1:0]    w_ham_term;
    logic signed [H_WIDTH-1:0]    w_h;
    logic signed [ACC_WIDTH-1:0]  w_shift;
    logic signed [ACC_WIDTH-1:0]  w_contrib;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic                         w_last;

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_in_sum = '0;
        for (int i = 0; i < VEC_LENGTH; i++)
            w_in_sum = w_in_sum + SUM_WIDTH'($signed(i_act[i*DATA_WIDTH +: DATA_WIDTH]));
    end

    // Duplicate indices count once per slot; indices at or above VEC_LENGTH add nothing.
    always_comb begin
        w_sel_sum = '0;
        for (int k = 0; k < NSEL; k++) begin
            if (int'(i_col_sel[k*SEL_WIDTH +: SEL_WIDTH]) < VEC_LENGTH)
                w_sel_sum = w_sel_sum + SUM_WIDTH'(r_act[i_col_sel[k*SEL_WIDTH +: ACT_IDX_WIDTH]]);
        end
    end

    always_comb begin
        w_ham_act  = (int'(i_col_ham_sel) < VEC_LENGTH) ? r_act[i_col_ham_sel[ACT_IDX_WIDTH-1:0]] : '0;
        w_p        = i_col_skip_zero ? H_WIDTH'(w_sel_sum)
                                     : H_WIDTH'(r_sum_act) - H_WIDTH'(w_sel_sum);
        w_ham_term = !i_col_ham_en  ? '0
                   : i_col_ham_sign ? -H_WIDTH'(w_ham_act) : H_WIDTH'(w_ham_act);
        w_h        = w_p + w_ham_term;
        w_shift    = ACC_WIDTH'(w_h) <<< r_col_idx;
        w_last     = (r_col_idx == LAST_COL);
        // The MSB column of a two's-complement weight carries negative weight.
        w_contrib  = (w_last && r_signed_w) ? -w_shift : w_shift;
        w_acc_next = r_acc + w_contrib;
    end

    // NOTE: the activation store is pure datapath and is not reset; it is always
    // reloaded before use, and the FSM reset alone guarantees no stale contribution.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && i_act_valid) begin
            for (int i = 0; i < VEC_LENGTH; i++)
                r_act[i] <= i_act[i*DATA_WIDTH +: DATA_WIDTH];
            r_signed_w <= i_act_signed_w;
            r_sum_act  <= w_in_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_col_idx   <= '0;
            r_result    <= '0;
            r_act_ready <= 1'b1;
            r_col_ready <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_act_valid) begin
                        r_acc       <= '0;
                        r_col_idx   <= '0;
                        r_state     <= COL;
                        r_act_ready <= 1'b0;
                        r_col_ready <= 1'b1;
                    end
                end
                COL: begin
                    if (i_col_valid) begin
                        r_acc     <= w_acc_next;
                        r_col_idx <= r_col_idx + IDX_WIDTH'(1);
                        if (w_last) begin
                            r_result    <= w_acc_next;
                            r_state     <= DONE;
                            r_col_ready <= 1'b0;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (i_res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_act_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_act_ready <= 1'b1;
                    r_col_ready <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_act_ready = r_act_ready;
    assign o_col_ready = r_col_ready;
    assign o_res_valid = r_res_valid;
    assign o_result    = r_result;

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Scoreboard bench for mac_unit_vert_seq: directed scenarios with fixed answers and
// random jobs whose answer is a plain integer dot product of random weight vectors.
module tb_mac_unit_vert_seq;
    localparam int DATA_WIDTH  = 8;
    localparam int VEC_LENGTH  = 16;
    localparam int WEIGHT_BITS = 8;
    localparam int NSEL        = VEC_LENGTH / 2;
    localparam int SEL_WIDTH   = $clog2(VEC_LENGTH) + 1;
    localparam int ACC_WIDTH   = DATA_WIDTH + WEIGHT_BITS + $clog2(VEC_LENGTH);
    localparam int SENTINEL    = VEC_LENGTH;
    localparam int TIMEOUT     = 100;

    typedef struct packed {
        logic [NSEL-1:0][SEL_WIDTH-1:0] sel;
        logic                           skip_zero;
        logic                           ham_en;
        logic                           ham_sign;
        logic [SEL_WIDTH-1:0]           ham_sel;
    } col_t;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             i_act_valid;
    logic                             o_act_ready;
    logic [VEC_LENGTH*DATA_WIDTH-1:0] i_act;
    logic                             i_act_signed_w;
    logic                             i_col_valid;
    logic                             o_col_ready;
    logic [NSEL*SEL_WIDTH-1:0]        i_col_sel;
    logic                             i_col_skip_zero;
    logic                             i_col_ham_en;
    logic                             i_col_ham_sign;
    logic [SEL_WIDTH-1:0]             i_col_ham_sel;
    logic                             o_res_valid;
    logic                             i_res_ready;
    logic signed [ACC_WIDTH-1:0]      o_result;

    mac_unit_vert_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LENGTH (VEC_LENGTH),
        .WEIGHT_BITS(WEIGHT_BITS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_act_valid    (i_act_valid),
        .o_act_ready    (o_act_ready),
        .i_act          (i_act),
        .i_act_signed_w (i_act_signed_w),
        .i_col_valid    (i_col_valid),
        .o_col_ready    (o_col_ready),
        .i_col_sel      (i_col_sel),
        .i_col_skip_zero(i_col_skip_zero),
        .i_col_ham_en   (i_col_ham_en),
        .i_col_ham_sign (i_col_ham_sign),
        .i_col_ham_sel  (i_col_ham_sel),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready),
        .o_result       (o_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [DATA_WIDTH-1:0] job_act [VEC_LENGTH];
    logic                         job_signed;
    col_t                         job_cols [WEIGHT_BITS];

    logic signed [ACC_WIDTH-1:0]  exp_q [$];
    string                        tag_q [$];
    logic signed [ACC_WIDTH-1:0]  mon_exp;
    string                        mon_tag;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within %0d cycles", name, TIMEOUT);
    endtask

    // Monitor: a result transfers at the next posedge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && o_res_valid && i_res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d, expected no result", o_result);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check({"result_", mon_tag}, longint'(o_result), longint'(mon_exp));
            end
        end
    end

    task automatic clear_cols();
        for (int j = 0; j < WEIGHT_BITS; j++) begin
            for (int k = 0; k < NSEL; k++) job_cols[j].sel[k] = SEL_WIDTH'(SENTINEL);
            job_cols[j].skip_zero = 1'b1;
            job_cols[j].ham_en    = 1'b0;
            job_cols[j].ham_sign  = 1'b0;
            job_cols[j].ham_sel   = SEL_WIDTH'(SENTINEL);
        end
    endtask

    task automatic random_acts();
        for (int i = 0; i < VEC_LENGTH; i++) job_act[i] = DATA_WIDTH'($urandom_range(0, 255));
    endtask

    task automatic send_act();
        int n;
        for (int i = 0; i < VEC_LENGTH; i++) i_act[i*DATA_WIDTH +: DATA_WIDTH] = job_act[i];
        i_act_signed_w = job_signed;
        i_act_valid    = 1'b1;
        n = 0;
        while (!o_act_ready && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_act_ready) timeout_fail("act_handshake");
        @(posedge clk); #1;
        i_act_valid = 1'b0;
    endtask

    task automatic send_col(input int j);
        int n;
        i_col_sel       = job_cols[j].sel;
        i_col_skip_zero = job_cols[j].skip_zero;
        i_col_ham_en    = job_cols[j].ham_en;
        i_col_ham_sign  = job_cols[j].ham_sign;
        i_col_ham_sel   = job_cols[j].ham_sel;
        i_col_valid     = 1'b1;
        n = 0;
        while (!o_col_ready && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_col_ready) timeout_fail("col_handshake");
        @(posedge clk); #1;
        i_col_valid = 1'b0;
        i_col_sel   = $urandom();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (o_res_valid && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        if (o_res_valid) timeout_fail("result_drain");
    endtask

    // Runs one full job; gap_after >= 0 inserts a 4-cycle col_valid gap after that column.
    task automatic run_job(input int gap_after, input logic signed [ACC_WIDTH-1:0] expected,
                           input string tag);
        exp_q.push_back(expected);
        tag_q.push_back(tag);
        check({"col_ready_idle_", tag}, longint'(o_col_ready), 0);
        send_act();
        check({"col_ready_after_act_", tag}, longint'(o_col_ready), 1);
        check({"act_ready_in_col_", tag}, longint'(o_act_ready), 0);
        for (int j = 0; j < WEIGHT_BITS; j++) begin
            send_col(j);
            if (j == gap_after && j < WEIGHT_BITS - 1) begin
                repeat (4) begin @(posedge clk); #1; end
            end
        end
        check({"res_valid_latency_", tag}, longint'(o_res_valid), 1);
        if (i_res_ready) drain();
    endtask

    // Builds descriptors from random weight vectors; expected is the plain dot product.
    task automatic build_random(output logic signed [ACC_WIDTH-1:0] expected);
        int     w [VEC_LENGTH];
        int     sel_list [$];
        int     ones;
        int     mode;
        int     y;
        logic   skip;
        longint dot;
        random_acts();
        job_signed = 1'($urandom_range(0, 1));
        for (int i = 0; i < VEC_LENGTH; i++) w[i] = int'($urandom_range(0, 255));
        dot = 0;
        for (int i = 0; i < VEC_LENGTH; i++)
            dot += longint'(job_act[i]) * longint'((job_signed && w[i] >= 128) ? w[i] - 256 : w[i]);
        expected = ACC_WIDTH'(dot);
        for (int j = 0; j < WEIGHT_BITS; j++) begin
            sel_list.delete();
            ones = 0;
            for (int i = 0; i < VEC_LENGTH; i++) ones += (w[i] >> j) & 1;
            skip = (ones <= NSEL);
            for (int i = 0; i < VEC_LENGTH; i++)
                if (((w[i] >> j) & 1) == int'(skip)) sel_list.push_back(i);
            mode = int'($urandom_range(0, 2));
            job_cols[j].skip_zero = skip;
            job_cols[j].ham_en    = 1'b0;
            job_cols[j].ham_sign  = 1'($urandom_range(0, 1));
            job_cols[j].ham_sel   = SEL_WIDTH'($urandom_range(0, 31));
            if (mode == 1 && sel_list.size() > 0) begin
                // Move one selected activation out of the list and add it back via Hamming.
                job_cols[j].ham_sel  = SEL_WIDTH'(sel_list.pop_back());
                job_cols[j].ham_en   = 1'b1;
                job_cols[j].ham_sign = !skip;
            end else if (mode == 2 && sel_list.size() < NSEL) begin
                // Select a spurious activation and cancel it via Hamming.
                y = int'($urandom_range(0, VEC_LENGTH - 1));
                sel_list.push_back(y);
                job_cols[j].ham_sel  = SEL_WIDTH'(y);
                job_cols[j].ham_en   = 1'b1;
                job_cols[j].ham_sign = skip;
            end
            for (int k = 0; k < NSEL; k++)
                job_cols[j].sel[k] = (k < sel_list.size()) ? SEL_WIDTH'(sel_list[k])
                                                           : SEL_WIDTH'($urandom_range(SENTINEL, 31));
        end
    endtask

    task automatic setup_all_ones();
        for (int i = 0; i < VEC_LENGTH; i++) job_act[i] = 8'sd1;
        job_signed = 1'b1;
        clear_cols();
        job_cols[0].skip_zero = 1'b0;
    endtask

    task automatic setup_negative(input logic sgn);
        for (int i = 0; i < VEC_LENGTH; i++) job_act[i] = DATA_WIDTH'(i - 8);
        job_signed = sgn;
        clear_cols();
        for (int j = 0; j < WEIGHT_BITS; j++) job_cols[j].skip_zero = 1'b0;
    endtask

    task automatic setup_msb(input logic sgn);
        random_acts();
        job_act[0] = -8'sd3;
        job_signed = sgn;
        clear_cols();
        job_cols[WEIGHT_BITS-1].sel[0] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [ACC_WIDTH-1:0] exp_val;
        reset = 1'b1;
        i_act_valid = 1'b0; i_act = '0; i_act_signed_w = 1'b0;
        i_col_valid = 1'b0; i_col_sel = '0; i_col_skip_zero = 1'b0;
        i_col_ham_en = 1'b0; i_col_ham_sign = 1'b0; i_col_ham_sel = '0;
        i_res_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        check("reset_result",    longint'(o_result),    0);
        check("reset_res_valid", longint'(o_res_valid), 0);
        check("reset_col_ready", longint'(o_col_ready), 0);
        check("reset_act_ready", longint'(o_act_ready), 1);

        setup_all_ones();
        run_job(-1, 16, "all_ones");
        setup_negative(1'b1);
        run_job(-1, 8, "neg_signed");
        setup_negative(1'b0);
        run_job(-1, -2040, "neg_unsigned");

        random_acts();
        job_act[3] = 8'sd10;
        job_act[5] = 8'sd4;
        job_signed = 1'b1;
        clear_cols();
        job_cols[0].sel[0]  = SEL_WIDTH'(3);
        job_cols[0].ham_en   = 1'b1;
        job_cols[0].ham_sign = 1'b1;
        job_cols[0].ham_sel  = SEL_WIDTH'(5);
        run_job(-1, 6, "hamming");

        setup_msb(1'b1);
        run_job(-1, 384, "msb_signed");
        setup_msb(1'b0);
        run_job(-1, -384, "msb_unsigned");

        // Backpressure: result must hold while res_ready is low.
        setup_msb(1'b1);
        i_res_ready = 1'b0;
        run_job(-1, 384, "backpressure");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_res_valid", longint'(o_res_valid), 1);
            check("bp_result",    longint'(o_result),    384);
            check("bp_act_ready", longint'(o_act_ready), 0);
            check("bp_col_ready", longint'(o_col_ready), 0);
        end
        i_res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_act_ready", longint'(o_act_ready), 1);
        check("bp_release_res_valid", longint'(o_res_valid), 0);

        // Reset in the middle of a job, after three columns.
        setup_negative(1'b1);
        send_act();
        for (int j = 0; j < 3; j++) send_col(j);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_result",    longint'(o_result),    0);
        check("midreset_res_valid", longint'(o_res_valid), 0);
        check("midreset_col_ready", longint'(o_col_ready), 0);
        check("midreset_act_ready", longint'(o_act_ready), 1);
        setup_all_ones();
        run_job(-1, 16, "after_midreset");

        // Same random job with and without a 4-cycle column gap.
        build_random(exp_val);
        run_job(-1, exp_val, "gapless");
        run_job(3, exp_val, "gapped");

        for (int t = 0; t < 40; t++) begin
            build_random(exp_val);
            run_job(int'($urandom_range(0, 12)), exp_val, $sformatf("rand%0d", t));
        end

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_unit_vert_seq.md
# mac_unit_vert_seq

Self-sequencing, parametrised bit-column ("vertical") MAC for the BitSim datapath. It dot-products one signed activation vector against a vector of WEIGHT_BITS-bit weights, one weight bit-column per accepted column descriptor. Each column sum is formed from a sparse list of selected activations, either the 1-bits or the complement against the internally computed activation sum, plus an optional ±1-activation Hamming correction. Column index, MSB handling, job framing and valid/ready handshakes are generated internally, so the PE array controller only streams descriptors.

## Interface
- DATA_WIDTH, 8, activation width (signed)
- VEC_LENGTH, 16, activations per vector
- WEIGHT_BITS, 8, weight bit-columns per job (≥2)
- NSEL, VEC_LENGTH/2, activation-select slots per column
- SEL_WIDTH, $clog2(VEC_LENGTH)+1, select index width; any index ≥ VEC_LENGTH selects 0
- SUM_WIDTH, DATA_WIDTH+$clog2(VEC_LENGTH), activation-sum width
- ACC_WIDTH, DATA_WIDTH+WEIGHT_BITS+$clog2(VEC_LENGTH), accumulator/result width
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- act_valid / act_ready  in / out  1  activation-vector handshake
- act  in  VEC_LENGTH×DATA_WIDTH  signed activations
- act_signed_w  in  1  1: weights are two's complement (MSB column negative); 0: unsigned
- col_valid / col_ready  in / out  1  column-descriptor handshake
- col_sel  in  NSEL×SEL_WIDTH  selected activation indices
- col_skip_zero  in  1  1: selected = weight bits equal to 1; 0: selected = bits equal to 0
- col_ham_en, col_ham_sign  in  1 each  Hamming correction enable, 1 = subtract
- col_ham_sel  in  SEL_WIDTH  Hamming activation index
- res_valid / res_ready  out / in  1  result handshake
- result  out  ACC_WIDTH  signed dot product

## Operation
- FSM states: IDLE, COL, DONE.
- IDLE: act_ready=1. On act_valid, register act and act_signed_w, register sum_act = Σact (SUM_WIDTH, signed), clear acc, clear col_idx, and go to COL.
- COL: col_ready=1. On each col_valid, using the registered act:
  - S = Σ act[col_sel[k]], with each index counted as often as it appears and out-of-range indices contributing 0.
  - P = col_skip_zero ? S : sum_act − S.
  - H = P + (col_ham_en ? (col_ham_sign ? −act[h] : act[h]) : 0), where h = col_ham_sel (out of range gives 0). H is SUM_WIDTH+1 bits, signed.
  - C = sign-extend(H) << col_idx. When col_idx = WEIGHT_BITS−1 and signed mode is set, C is negated.
  - acc += C (ACC_WIDTH, wraps modulo 2^ACC_WIDTH) and col_idx increments.
  - On acceptance of column WEIGHT_BITS−1, result ← acc + C and the FSM goes to DONE.
- DONE: res_valid=1. When res_ready=1, go to IDLE. act_ready and col_ready are 0 in DONE.
- result holds the last completed value until the next job completes.
- Reset in any state, including mid-job:
  - next cycle state=IDLE, acc=0, col_idx=0, result=0;
  - res_valid=0, col_ready=0, act_ready=1;
  - no partial contribution survives.

## Timing
- Handshakes transfer on the posedge with valid&ready. Ready signals are functions of state only and never of the same-cycle valid.
- Act accepted at cycle t: col_ready is first high at t+1.
- Columns are accepted at most one per cycle. Gaps on col_valid stall without changing acc.
- Last column accepted at cycle u: res_valid=1 and result valid from u+1. Minimum job period is WEIGHT_BITS+2 cycles.
- result and res_valid are stable while res_valid=1 and res_ready=0.
- Column arithmetic is single-cycle combinational from registered act/sum_act. There is no internal pipeline, so no flush is needed.

## Test plan
- Reset: hold reset for 2 cycles, then release.
  - Required: result=0, res_valid=0, col_ready=0, act_ready=1.
  - Assert reset mid-COL after 3 columns: a new job (next scenario) returns exactly 16.
- All-ones case: VEC_LENGTH=16, act all +1, signed mode, weights all 1.
  - Column 0: col_skip_zero=0, all sel=16 (sentinel).
  - Columns 1–7: col_skip_zero=1, all sel=16.
  - Required: result=16, valid at the cycle after column 7 is accepted.
- Negative weights: act[i]=i−8, signed mode, weights all −1 (every column col_skip_zero=0 with all sentinels).
  - Required: result=+8.
  - The same job in unsigned mode (weights 255) requires result=−2040.
- Hamming correction: column 0 with col_skip_zero=1, sel={3, sentinels}, act[3]=10, ham_en=1, ham_sign=1, ham_sel=5, act[5]=4.
  - Remaining columns empty. Required: result=6.
- MSB sign: only column 7 non-empty, with sel={0} and act[0]=−3.
  - Signed mode requires result=+384; unsigned mode requires result=−384.
- Backpressure:
  - Hold res_ready=0 for 5 cycles: result stable, res_valid=1, act_ready=col_ready=0. Assert res_ready: next cycle IDLE.
  - Deassert col_valid for 4 cycles mid-job: result is unchanged versus the gapless run.
